// File: rtl/cpu_datapath.sv
// ---------------------------------------------------------------------------
// cpu_datapath
// 32-bit single-bus datapath of the teaching CPU. Sixteen general registers,
// PC, IR, MAR, MDR, Y, the 64-bit Z result register, HI/LO, the ALU, the
// select-and-encode logic and an internal RAM all meet on one shared bus
// (BusMuxOut). The block has no sequencing of its own: an external control
// FSM (or a testbench) raises the enables it wants on every cycle.
//
// The RAM has no defined power-up contents and is not touched by reset.
// Words are placed in it through MAR/MDR with Write.
//
// Ports
//   clk, clr                  clock; asynchronous active-low reset
//   R_rd_diog / R_wrt_diog    direct one-hot load / drive enables, R0..R15
//   Rin, R_out, BAout         load / drive enables for the register picked
//                             by Gra/Grb/Grc (BAout makes R0 read as zero)
//   Gra, Grb, Grc             pick the Ra / Rb / Rc field of IR
//   *_out                     bus source selects
//   MAR_rd..Y_rd              register load enables
//   IncPC                     PC+1, and forces the ALU to compute bus+1
//   op_sel                    ALU operation
//   Read, Write               RAM -> MDR / MDR -> RAM
//   *_view, BusMuxOut         combinational copies of internal state
// ---------------------------------------------------------------------------
module cpu_datapath #(
    parameter int MEM_DEPTH = 512
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [15:0]                  R_rd_diog,
    input  logic [15:0]                  R_wrt_diog,
    input  logic                         Rin,
    input  logic                         R_out,
    input  logic                         Gra,
    input  logic                         Grb,
    input  logic                         Grc,
    input  logic                         BAout,
    input  logic                         HI_out,
    input  logic                         LO_out,
    input  logic                         Zhi_out,
    input  logic                         Zlo_out,
    input  logic                         PC_out,
    input  logic                         MDR_out,
    input  logic                         MAR_out,
    input  logic                         In_out,
    input  logic                         C_out,
    input  logic                         MAR_rd,
    input  logic                         Zlo_rd,
    input  logic                         PC_rd,
    input  logic                         MDR_rd,
    input  logic                         IR_rd,
    input  logic                         Y_rd,
    input  logic                         IncPC,
    input  logic [4:0]                   op_sel,
    input  logic                         Read,
    input  logic                         Write,
    output logic [31:0]                  r5_view,
    output logic [31:0]                  r6_view,
    output logic [31:0]                  Y_view,
    output logic [31:0]                  Zlo_view,
    output logic [31:0]                  MDR_view,
    output logic [31:0]                  PC_view,
    output logic [31:0]                  IR_view,
    output logic [$clog2(MEM_DEPTH)-1:0] MAR_view,
    output logic [31:0]                  BusMuxOut,
    output logic [31:0]                  C_extended_view,
    output logic [31:0]                  regControl_view
);

    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic [31:0] r_regs [16];
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [AW-1:0] r_mar;
    logic [31:0] r_mdr;
    logic [31:0] r_y;
    logic [63:0] r_z;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mem [MEM_DEPTH];

    logic [3:0]  w_field;
    logic [15:0] w_sel;
    logic [15:0] w_load;
    logic [15:0] w_drive;
    logic [31:0] w_r0Bus;
    logic [31:0] w_regBus;
    logic [31:0] w_cExt;
    logic [31:0] w_bus;
    logic [31:0] w_memData;
    logic [4:0]  w_shamt;
    logic [5:0]  w_shamtInv;
    logic [31:0] w_shra;
    logic [31:0] w_ror;
    logic [31:0] w_rol;
    logic [63:0] w_product;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_alu;

    // Select-and-encode: Gra outranks Grb, which outranks Grc. With no field
    // selected the decoded one-hot is empty, so Rin/R_out alone touch nothing.
    assign w_field = Gra ? r_ir[26:23] : (Grb ? r_ir[22:19] : r_ir[18:15]);
    assign w_sel   = (Gra | Grb | Grc) ? (16'h0001 << w_field) : 16'h0000;
    assign w_load  = R_rd_diog | (Rin ? w_sel : 16'h0000);
    assign w_drive = R_wrt_diog | ((R_out | BAout) ? w_sel : 16'h0000);

    // Base-address reads treat a selected R0 as the constant zero.
    assign w_r0Bus = (BAout && w_sel[0]) ? 32'h0 : r_regs[0];

    assign w_cExt    = {{13{r_ir[18]}}, r_ir[18:0]};
    assign w_memData = r_mem[r_mar];

    // Register source for the bus: the lowest-numbered driving register wins.
    always_comb begin
        w_regBus = 32'h0;
        for (int i = 15; i >= 1; i--) begin
            if (w_drive[i]) begin
                w_regBus = r_regs[i];
            end
        end
        if (w_drive[0]) begin
            w_regBus = w_r0Bus;
        end
    end

    // Shared bus. Control should only ever raise one source; if several are
    // raised the order below decides, and an idle bus reads zero.
    always_comb begin
        w_bus = 32'h0;
        if (|w_drive)     w_bus = w_regBus;
        else if (HI_out)  w_bus = r_hi;
        else if (LO_out)  w_bus = r_lo;
        else if (Zhi_out) w_bus = r_z[63:32];
        else if (Zlo_out) w_bus = r_z[31:0];
        else if (PC_out)  w_bus = r_pc;
        else if (MDR_out) w_bus = r_mdr;
        else if (MAR_out) w_bus = {{(32-AW){1'b0}}, r_mar};
        else if (In_out)  w_bus = 32'h0;
        else if (C_out)   w_bus = w_cExt;
    end

    // Shift and rotate helpers; Y is shifted by the low five bits of the bus.
    // A shift by 32 of a 32-bit value yields zero, which makes the
    // rotate-by-zero case come out right without a special case.
    assign w_shamt    = w_bus[4:0];
    assign w_shamtInv = 6'd32 - {1'b0, w_shamt};
    assign w_shra     = $signed(r_y) >>> w_shamt;
    assign w_ror      = (r_y >> w_shamt) | (r_y << w_shamtInv);
    assign w_rol      = (r_y << w_shamt) | (r_y >> w_shamtInv);
    assign w_product  = $signed({{32{r_y[31]}}, r_y}) * $signed({{32{w_bus[31]}}, w_bus});

    // Signed divide; a zero divisor gives zero quotient and remainder.
    always_comb begin
        w_quot = 32'h0;
        w_rem  = 32'h0;
        if (w_bus != 32'h0) begin
            w_quot = $signed(r_y) / $signed(w_bus);
            w_rem  = $signed(r_y) % $signed(w_bus);
        end
    end

    // ALU: A is Y, B is the bus. IncPC hijacks the ALU for the bus+1 used
    // during fetch. Only MUL and DIV produce a non-zero upper half.
    always_comb begin
        w_alu = 64'h0;
        if (IncPC) begin
            w_alu = {32'h0, w_bus + 32'h1};
        end else begin
            case (op_sel)
                OP_ADD:  w_alu = {32'h0, r_y + w_bus};
                OP_SUB:  w_alu = {32'h0, r_y - w_bus};
                OP_AND:  w_alu = {32'h0, r_y & w_bus};
                OP_OR:   w_alu = {32'h0, r_y | w_bus};
                OP_SHR:  w_alu = {32'h0, r_y >> w_shamt};
                OP_SHRA: w_alu = {32'h0, w_shra};
                OP_SHL:  w_alu = {32'h0, r_y << w_shamt};
                OP_ROR:  w_alu = {32'h0, w_ror};
                OP_ROL:  w_alu = {32'h0, w_rol};
                OP_MUL:  w_alu = w_product;
                OP_DIV:  w_alu = {w_rem, w_quot};
                OP_NEG:  w_alu = {32'h0, 32'h0 - w_bus};
                OP_NOT:  w_alu = {32'h0, ~w_bus};
                default: w_alu = 64'h0;
            endcase
        end
    end

    // General register file, loaded from the bus.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (w_load[i]) begin
                    r_regs[i] <= w_bus;
                end
            end
        end
    end

    // Special registers. PC_rd beats IncPC. MDR takes RAM data on Read,
    // otherwise the bus; when Read and Write collide the write alone happens
    // and MDR keeps the value being written. HI/LO have no load path here.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_pc  <= 32'h0;
            r_ir  <= 32'h0;
            r_mar <= '0;
            r_mdr <= 32'h0;
            r_y   <= 32'h0;
            r_z   <= 64'h0;
            r_hi  <= 32'h0;
            r_lo  <= 32'h0;
        end else begin
            if (PC_rd) begin
                r_pc <= w_bus;
            end else if (IncPC) begin
                r_pc <= r_pc + 32'h1;
            end
            if (IR_rd)  r_ir  <= w_bus;
            if (MAR_rd) r_mar <= w_bus[AW-1:0];
            if (Y_rd)   r_y   <= w_bus;
            if (Zlo_rd) r_z   <= w_alu;
            if (MDR_rd && !(Read && Write)) begin
                r_mdr <= Read ? w_memData : w_bus;
            end
            r_hi <= 32'h0;
            r_lo <= 32'h0;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (Write) begin
            r_mem[r_mar] <= r_mdr;
        end
    end

    assign r5_view         = r_regs[5];
    assign r6_view         = r_regs[6];
    assign Y_view          = r_y;
    assign Zlo_view        = r_z[31:0];
    assign MDR_view        = r_mdr;
    assign PC_view         = r_pc;
    assign IR_view         = r_ir;
    assign MAR_view        = r_mar;
    assign BusMuxOut       = w_bus;
    assign C_extended_view = w_cExt;
    assign regControl_view = {w_load, w_drive};

endmodule

// File: tb/tb_cpu_datapath.sv
// ---------------------------------------------------------------------------
// tb_cpu_datapath
// Self-checking bench for cpu_datapath. Arbitrary 32-bit values are built in
// Z by repeated doubling and increment, then moved over the bus into the
// register that needs them. ALU results are compared against a reference
// function written from the operation definitions.
// ---------------------------------------------------------------------------
module tb_cpu_datapath;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] R_rd_diog, R_wrt_diog;
    logic        Rin, R_out, Gra, Grb, Grc, BAout;
    logic        HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out;
    logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, IncPC;
    logic [4:0]  op_sel;
    logic        Read, Write;
    logic [31:0] r5_view, r6_view, Y_view, Zlo_view, MDR_view, PC_view, IR_view;
    logic [8:0]  MAR_view;
    logic [31:0] BusMuxOut, C_extended_view, regControl_view;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] oriWord;

    cpu_datapath dut (
        .clk(clk), .clr(clr),
        .R_rd_diog(R_rd_diog), .R_wrt_diog(R_wrt_diog),
        .Rin(Rin), .R_out(R_out), .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout),
        .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
        .PC_out(PC_out), .MDR_out(MDR_out), .MAR_out(MAR_out), .In_out(In_out), .C_out(C_out),
        .MAR_rd(MAR_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd),
        .Y_rd(Y_rd), .IncPC(IncPC), .op_sel(op_sel), .Read(Read), .Write(Write),
        .r5_view(r5_view), .r6_view(r6_view), .Y_view(Y_view), .Zlo_view(Zlo_view),
        .MDR_view(MDR_view), .PC_view(PC_view), .IR_view(IR_view), .MAR_view(MAR_view),
        .BusMuxOut(BusMuxOut), .C_extended_view(C_extended_view),
        .regControl_view(regControl_view)
    );

    always #5 clk = ~clk;

    // Reference ALU built from the operation definitions (bitwise loops for
    // shifts and rotates, wide integer arithmetic for MUL/DIV).
    function automatic logic [63:0] refAlu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        int          ia = a;
        int          ib = b;
        int          sh = int'(b[4:0]);
        logic [31:0] r  = a;
        longint      p;
        case (op)
            5'b00011: return {32'h0, a + b};
            5'b00100: return {32'h0, a - b};
            5'b00101: return {32'h0, a & b};
            5'b00110: return {32'h0, a | b};
            5'b00111: begin for (int k = 0; k < sh; k++) r = {1'b0, r[31:1]};  return {32'h0, r}; end
            5'b01000: begin for (int k = 0; k < sh; k++) r = {r[31], r[31:1]}; return {32'h0, r}; end
            5'b01001: begin for (int k = 0; k < sh; k++) r = {r[30:0], 1'b0};  return {32'h0, r}; end
            5'b01010: begin for (int k = 0; k < sh; k++) r = {r[0], r[31:1]};  return {32'h0, r}; end
            5'b01011: begin for (int k = 0; k < sh; k++) r = {r[30:0], r[31]}; return {32'h0, r}; end
            5'b01111: begin p = longint'(ia) * longint'(ib); return p; end
            5'b10000: begin
                if (ib == 0) return 64'h0;
                return {32'(ia % ib), 32'(ia / ib)};
            end
            5'b10001: return {32'h0, -b};
            5'b10010: return {32'h0, ~b};
            default:  return 64'h0;
        endcase
    endfunction

    task automatic clearCtl();
        R_rd_diog = 16'h0; R_wrt_diog = 16'h0;
        Rin = 0; R_out = 0; Gra = 0; Grb = 0; Grc = 0; BAout = 0;
        HI_out = 0; LO_out = 0; Zhi_out = 0; Zlo_out = 0; PC_out = 0;
        MDR_out = 0; MAR_out = 0; In_out = 0; C_out = 0;
        MAR_rd = 0; Zlo_rd = 0; PC_rd = 0; MDR_rd = 0; IR_rd = 0; Y_rd = 0; IncPC = 0;
        op_sel = 5'b00000; Read = 0; Write = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Builds v in Z (clobbers Y and PC along the way).
    task automatic makeZ(input logic [31:0] v);
        bit started = 0;
        clearCtl(); Zlo_rd = 1; tick();
        for (int i = 31; i >= 0; i--) begin
            if (started) begin
                clearCtl(); Zlo_out = 1; Y_rd = 1; tick();
                clearCtl(); Zlo_out = 1; op_sel = OP_ADD; Zlo_rd = 1; tick();
            end
            if (v[i]) begin
                clearCtl(); Zlo_out = 1; IncPC = 1; Zlo_rd = 1; tick();
                started = 1;
            end
        end
        clearCtl();
    endtask

    task automatic loadReg(input int idx, input logic [31:0] v);
        makeZ(v);
        Zlo_out = 1; R_rd_diog = 16'h0001 << idx; tick(); clearCtl();
    endtask

    task automatic loadY(input logic [31:0] v);
        makeZ(v); Zlo_out = 1; Y_rd = 1; tick(); clearCtl();
    endtask

    task automatic loadPC(input logic [31:0] v);
        makeZ(v); Zlo_out = 1; PC_rd = 1; tick(); clearCtl();
    endtask

    task automatic loadIR(input logic [31:0] v);
        makeZ(v); Zlo_out = 1; IR_rd = 1; tick(); clearCtl();
    endtask

    task automatic writeMem(input logic [8:0] addr, input logic [31:0] v);
        makeZ({23'h0, addr}); Zlo_out = 1; MAR_rd = 1; tick(); clearCtl();
        makeZ(v); Zlo_out = 1; MDR_rd = 1; tick(); clearCtl();
        Write = 1; tick(); clearCtl();
    endtask

    task automatic readMem(input logic [8:0] addr, output logic [31:0] v);
        makeZ({23'h0, addr}); Zlo_out = 1; MAR_rd = 1; tick(); clearCtl();
        Read = 1; MDR_rd = 1; tick(); clearCtl();
        v = MDR_view;
    endtask

    // One ALU operation with A=Y=a and B=R1=b; returns both halves of Z.
    task automatic runAlu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic inc, output logic [31:0] lo, output logic [31:0] hi);
        loadReg(1, b);
        loadY(a);
        R_wrt_diog = 16'h0002; op_sel = op; IncPC = inc; Zlo_rd = 1; tick(); clearCtl();
        lo = Zlo_view;
        Zhi_out = 1; #1; hi = BusMuxOut; Zhi_out = 0;
    endtask

    // All views must read zero while reset is held.
    task automatic checkViewsZero(input string tag);
        logic [31:0] obs [11];
        string       nm  [11];
        obs = '{r5_view, r6_view, Y_view, Zlo_view, MDR_view, PC_view, IR_view,
                {23'h0, MAR_view}, BusMuxOut, C_extended_view, regControl_view};
        nm  = '{"r5", "r6", "Y", "Zlo", "MDR", "PC", "IR", "MAR", "bus", "Cext", "regCtl"};
        for (int i = 0; i < 11; i++) begin
            checkCount++;
            if (obs[i] !== 32'h0)
                $display("[TB] FAIL %s_%s got %h expected 00000000", tag, nm[i], obs[i]);
            else passCount++;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; clearCtl();
        #1 clr = 1'b0;
        #2;
        checkViewsZero("reset");
        #2 clr = 1'b1;
        tick();
    endtask

    task automatic test_preload();
        writeMem(9'd0, 32'h45);
        loadPC(32'h0);
        PC_out = 1; MAR_rd = 1; tick(); clearCtl();
        Read = 1; MDR_rd = 1; tick(); clearCtl();
        MDR_out = 1; R_rd_diog = 16'h0020; tick(); clearCtl();
        checkCount++;
        if (r5_view !== 32'h45) $display("[TB] FAIL preload_r5 got %h expected 00000045", r5_view);
        else passCount++;
        checkCount++;
        if (MDR_view !== 32'h45) $display("[TB] FAIL preload_mdr got %h expected 00000045", MDR_view);
        else passCount++;
    endtask

    task automatic test_fetch_ori();
        oriWord = {5'b01101, 4'd5, 4'd6, 19'h00095};
        writeMem(9'd4, oriWord);
        loadReg(6, 32'h50);
        loadPC(32'h4);
        // T0
        PC_out = 1; MAR_rd = 1; IncPC = 1; Zlo_rd = 1; tick(); clearCtl();
        checkCount++;
        if (Zlo_view !== 32'h5) $display("[TB] FAIL t0_zlo got %h expected 00000005", Zlo_view);
        else passCount++;
        checkCount++;
        if (MAR_view !== 9'd4) $display("[TB] FAIL t0_mar got %h expected 004", MAR_view);
        else passCount++;
        // T1
        Zlo_out = 1; PC_rd = 1; Read = 1; MDR_rd = 1; tick(); clearCtl();
        checkCount++;
        if (PC_view !== 32'h5) $display("[TB] FAIL t1_pc got %h expected 00000005", PC_view);
        else passCount++;
        checkCount++;
        if (MDR_view !== oriWord) $display("[TB] FAIL t1_mdr got %h expected %h", MDR_view, oriWord);
        else passCount++;
        // T2
        MDR_out = 1; IR_rd = 1; tick(); clearCtl();
        checkCount++;
        if (IR_view !== oriWord) $display("[TB] FAIL t2_ir got %h expected %h", IR_view, oriWord);
        else passCount++;
        checkCount++;
        if (C_extended_view !== 32'h95) $display("[TB] FAIL t2_cext got %h expected 00000095", C_extended_view);
        else passCount++;
        // T3
        Grb = 1; BAout = 1; R_out = 1; Y_rd = 1; #1;
        checkCount++;
        if (BusMuxOut !== 32'h50) $display("[TB] FAIL t3_bus got %h expected 00000050", BusMuxOut);
        else passCount++;
        tick(); clearCtl();
        checkCount++;
        if (Y_view !== 32'h50) $display("[TB] FAIL t3_y got %h expected 00000050", Y_view);
        else passCount++;
        // T4
        C_out = 1; op_sel = OP_OR; Zlo_rd = 1; tick(); clearCtl();
        checkCount++;
        if (Zlo_view !== 32'hD5) $display("[TB] FAIL t4_zlo got %h expected 000000d5", Zlo_view);
        else passCount++;
        // T5
        Zlo_out = 1; Gra = 1; Rin = 1; tick(); clearCtl();
        checkCount++;
        if (r5_view !== 32'hD5) $display("[TB] FAIL t5_r5 got %h expected 000000d5", r5_view);
        else passCount++;
    endtask

    task automatic test_baout();
        loadReg(0, 32'h1234);
        loadIR({5'd0, 4'd3, 4'd0, 19'h0});
        Grb = 1; BAout = 1; #1;
        checkCount++;
        if (BusMuxOut !== 32'h0) $display("[TB] FAIL baout_r0 got %h expected 00000000", BusMuxOut);
        else passCount++;
        checkCount++;
        if (regControl_view !== 32'h0000_0001) $display("[TB] FAIL baout_ctl got %h expected 00000001", regControl_view);
        else passCount++;
        BAout = 0; R_out = 1; #1;
        checkCount++;
        if (BusMuxOut !== 32'h1234) $display("[TB] FAIL rout_r0 got %h expected 00001234", BusMuxOut);
        else passCount++;
        Rin = 1; R_rd_diog = 16'h0100; R_wrt_diog = 16'h0040; #1;
        checkCount++;
        if (regControl_view !== 32'h0101_0041) $display("[TB] FAIL regctl_merge got %h expected 01010041", regControl_view);
        else passCount++;
        clearCtl(); tick();
    endtask

    task automatic test_bus_priority();
        loadReg(2, 32'hCAFE1234);
        loadPC(32'h77);
        MDR_out = 1; PC_out = 1; R_wrt_diog = 16'h0004; #1;
        checkCount++;
        if (BusMuxOut !== 32'hCAFE1234) $display("[TB] FAIL prio_reg got %h expected cafe1234", BusMuxOut);
        else passCount++;
        R_wrt_diog = 16'h0; #1;
        checkCount++;
        if (BusMuxOut !== 32'h77) $display("[TB] FAIL prio_pc got %h expected 00000077", BusMuxOut);
        else passCount++;
        HI_out = 1; #1;
        checkCount++;
        if (BusMuxOut !== 32'h0) $display("[TB] FAIL prio_hi got %h expected 00000000", BusMuxOut);
        else passCount++;
        clearCtl(); MAR_out = 1; #1;
        checkCount++;
        if (BusMuxOut !== {23'h0, MAR_view} || MAR_view !== 9'd4)
            $display("[TB] FAIL mar_zext got %h expected 00000004", BusMuxOut);
        else passCount++;
        clearCtl(); In_out = 1; C_out = 1; #1;
        checkCount++;
        if (BusMuxOut !== 32'h0) $display("[TB] FAIL prio_in got %h expected 00000000", BusMuxOut);
        else passCount++;
        clearCtl(); tick();
    endtask

    task automatic test_pc();
        makeZ(32'h100);
        Zlo_out = 1; PC_rd = 1; IncPC = 1; tick(); clearCtl();
        checkCount++;
        if (PC_view !== 32'h100) $display("[TB] FAIL pc_rd_wins got %h expected 00000100", PC_view);
        else passCount++;
        IncPC = 1; tick(); clearCtl();
        checkCount++;
        if (PC_view !== 32'h101) $display("[TB] FAIL pc_inc got %h expected 00000101", PC_view);
        else passCount++;
    endtask

    task automatic test_alu_corners();
        logic [31:0] lo, hi;
        runAlu(OP_SHRA, 32'h80000000, 32'h1, 1'b0, lo, hi);
        checkCount++;
        if (lo !== 32'hC0000000) $display("[TB] FAIL shra_lo got %h expected c0000000", lo);
        else passCount++;
        runAlu(OP_MUL, 32'hFFFFFFFF, 32'h2, 1'b0, lo, hi);
        checkCount++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE)
            $display("[TB] FAIL mul_neg got %h_%h expected ffffffff_fffffffe", hi, lo);
        else passCount++;
        runAlu(OP_DIV, 32'h1234567, 32'h0, 1'b0, lo, hi);
        checkCount++;
        if (hi !== 32'h0 || lo !== 32'h0) $display("[TB] FAIL div_zero got %h_%h expected 0_0", hi, lo);
        else passCount++;
        runAlu(OP_MUL, 32'h7, 32'hA, 1'b1, lo, hi);
        checkCount++;
        if (hi !== 32'h0 || lo !== 32'hB) $display("[TB] FAIL incpc_override got %h_%h expected 0_b", hi, lo);
        else passCount++;
    endtask

    task automatic test_alu_random();
        logic [4:0]  ops [16] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                  5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001,
                                  5'b10010, 5'b00000, 5'b01100, 5'b11111};
        logic [4:0]  op;
        logic [31:0] a, b, lo, hi;
        logic        inc;
        logic [63:0] exp;
        for (int n = 0; n < 24; n++) begin
            op  = ops[$urandom_range(0, 15)];
            a   = $urandom;
            b   = $urandom;
            inc = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 3);
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'h3;
            exp = inc ? {32'h0, b + 32'h1} : refAlu(op, a, b);
            runAlu(op, a, b, inc, lo, hi);
            checkCount++;
            if (lo !== exp[31:0])
                $display("[TB] FAIL alu_lo op=%b a=%h b=%h inc=%b got %h expected %h", op, a, b, inc, lo, exp[31:0]);
            else passCount++;
            checkCount++;
            if (hi !== exp[63:32])
                $display("[TB] FAIL alu_hi op=%b a=%h b=%h inc=%b got %h expected %h", op, a, b, inc, hi, exp[63:32]);
            else passCount++;
        end
    endtask

    task automatic test_midrun_reset();
        logic [31:0] v;
        loadReg(5, 32'hA5A5A5A5);
        loadReg(6, 32'h5A5A5A5A);
        loadIR(32'h0004_0001);
        clr = 1'b0;
        #2;
        checkViewsZero("midreset");
        #1 clr = 1'b1;
        tick();
        readMem(9'd0, v);
        checkCount++;
        if (v !== 32'h45) $display("[TB] FAIL ram_keep0 got %h expected 00000045", v);
        else passCount++;
        readMem(9'd4, v);
        checkCount++;
        if (v !== oriWord) $display("[TB] FAIL ram_keep4 got %h expected %h", v, oriWord);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_preload();
        test_fetch_ori();
        test_baout();
        test_bus_priority();
        test_pc();
        test_alu_corners();
        test_alu_random();
        test_midrun_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
